otp_bank_sched: RTL
===================

// Module: otp_bank_sched
// PURPOSE
//  Ping-pong scheduler for the two OTP keystream banks between otp_gen (producer) and the sd core (consumer).
//  Each bank holds one 512-byte block of keystream, i.e. 1024 nibbles.
//  Starts otp_gen on a free bank, tells sd when a full bank is ready, and recycles banks as sd releases them.
//  Counts blocks over a session and flags protocol errors. Sits between sd, otp_gen and the bank RAMs.
// PARAMETERS
//  BLK_W  16  width of the block counters; up to 2**BLK_W-1 blocks per session
// PORTS
//  iclk       in   1      system clock; every input is synchronous to iclk (sd-side signals are synchronised upstream)
//  irst       in   1      reset, asynchronous, active-low
//  istart     in   1      1-cycle pulse: begin a session; ignored while obusy=1
//  iblocks    in   BLK_W  number of blocks in the session; sampled on istart
//  ogen_otp   out  1      1-cycle pulse: otp_gen starts filling bank owbank
//  onew_otp   out  1      driven with ogen_otp: 1 = advance the keystream counter (every block except the first)
//  owbank     out  1      bank otp_gen writes to; stable from ogen_otp until iotp_done
//  iotp_done  in   1      1-cycle pulse: otp_gen has finished the current bank
//  otp_ready  out  1      level: bank orbank is FULL and sd may read it
//  orbank     out  1      bank sd reads from
//  irelease   in   1      1-cycle pulse: sd is done with bank orbank
//  obusy      out  1      session in progress
//  odone      out  1      1-cycle pulse: the last block of the session has been released
//  oerr       out  1      sticky protocol error; cleared by the next accepted istart
// BEHAVIOUR
//  Reset: all outputs 0. Both banks EMPTY. wptr = rptr = 0. Counters 0. FSM in IDLE. All outputs are registered.
//  Per-bank state: EMPTY -> FILLING (on ogen_otp) -> FULL (on iotp_done) -> EMPTY (on irelease).
//  Top FSM:
//   - IDLE: on istart with iblocks!=0, load gen_left = rel_left = iblocks, set first=1, clear oerr, go to RUN.
//   - IDLE: on istart with iblocks==0, pulse odone on the next cycle. No ogen_otp. Stay in IDLE.
//   - RUN: obusy=1. Leave RUN only when rel_left reaches 0, or on reset.
//  Producer (in RUN):
//   - Fires when gen_left!=0, bank[wptr]==EMPTY and no bank is FILLING.
//   - Next cycle: ogen_otp=1, owbank=wptr, onew_otp=~first; bank[wptr] becomes FILLING; first is cleared.
//   - On iotp_done: bank[owbank] becomes FULL, wptr toggles, gen_left decrements.
//   - The next ogen_otp is no earlier than the cycle after iotp_done.
//  Consumer:
//   - otp_ready = (bank[rptr]==FULL); orbank = rptr.
//   - On irelease with otp_ready=1: bank[rptr] becomes EMPTY, rptr toggles, rel_left decrements.
//   - When rel_left goes 1->0: odone pulses on the next cycle, obusy drops with it, FSM returns to IDLE.
//  Latency:
//   - istart at cycle t -> ogen_otp at t+1.
//   - iotp_done at t -> otp_ready=1 at t+1.
//   - irelease at t -> otp_ready reflects the next bank at t+1.
//   - irelease freeing the bank the producer waits on (at t) -> ogen_otp at t+2.
//  Simultaneous iotp_done and irelease: they always hit different banks, so both take effect in the same cycle.
//  Both banks FULL: producer stalls, no ogen_otp until a release. Both banks EMPTY: otp_ready=0.
//  Last block generated (gen_left==0): no further ogen_otp; the remaining FULL banks still drain normally.
//  Errors (oerr set; the offending event is otherwise ignored and bank state is unchanged):
//   - irelease while otp_ready=0
//   - iotp_done while no bank is FILLING
//   - irelease or iotp_done while in IDLE
//  istart while obusy=1: ignored. Does not set oerr.
//  Reset mid-session: immediate return to reset values. No odone. otp_gen and sd are reset by the same irst.
//  Counter width: counters never wrap; the rules above keep them from decrementing below 0.
// TESTING
//  1. istart, iblocks=1; iotp_done 1024 cycles after ogen_otp; irelease 5 cycles later.
//     -> one ogen_otp with onew_otp=0, owbank=0; otp_ready 1 cycle after done; odone 1 cycle after release.
//  2. iblocks=4, sd releases instantly.
//     -> ogen_otp with owbank sequence 0,1,0,1 and onew_otp sequence 0,1,1,1; odone after the 4th release.
//  3. iblocks=3, sd never releases.
//     -> two ogen_otp, both banks FULL, producer stalls.
//     -> one irelease gives the 3rd ogen_otp exactly 2 cycles later, on bank 0.
//  4. iotp_done on bank 1 in the same cycle as irelease of bank 0.
//     -> both applied; otp_ready stays 1 with orbank=1; next ogen_otp on bank 0.
//  5. irelease with otp_ready=0, then a stray iotp_done.
//     -> oerr=1, counters unchanged; the next istart clears oerr.
//  6. iblocks=0 -> odone at t+1, no ogen_otp. irst low mid-session -> all outputs 0 at once, no odone.

Source files
------------

// File: rtl/otp_bank_sched_if.sv
// otp_bank_sched_if
//  Bundles the session, producer (otp_gen) and consumer (sd) handshakes of
//  the OTP ping-pong bank scheduler.
//  slave  : the scheduler side (drives gen_otp/new_otp/wbank/otp_ready/rbank/
//           busy/done/err, receives start/blocks/otp_done/rel)
//  master : the controller/otp_gen/sd side (mirror image)
//  Signals:
//   start     1-cycle pulse, begin a session (ignored while busy)
//   blocks    number of 512-byte blocks in the session, sampled on start
//   gen_otp   1-cycle pulse, otp_gen starts filling bank wbank
//   new_otp   with gen_otp: advance the keystream counter (all but the first block)
//   wbank     bank otp_gen writes to
//   otp_done  1-cycle pulse, otp_gen finished the current bank
//   otp_ready level, bank rbank is full and may be read
//   rbank     bank sd reads from
//   rel       1-cycle pulse, sd is done with bank rbank
//   busy      session in progress
//   done      1-cycle pulse, last block of the session released
//   err       sticky protocol error
interface otp_bank_sched_if #(
    parameter int BLK_W = 16
);
    logic             start;
    logic [BLK_W-1:0] blocks;
    logic             gen_otp;
    logic             new_otp;
    logic             wbank;
    logic             otp_done;
    logic             otp_ready;
    logic             rbank;
    logic             rel;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  start, blocks, otp_done, rel,
        output gen_otp, new_otp, wbank, otp_ready, rbank, busy, done, err
    );

    modport master (
        output start, blocks, otp_done, rel,
        input  gen_otp, new_otp, wbank, otp_ready, rbank, busy, done, err
    );
endinterface

// File: rtl/otp_bank_sched.sv
// otp_bank_sched
//  Ping-pong scheduler for the two OTP keystream banks (1024 nibbles each)
//  between otp_gen (producer) and the sd core (consumer). Launches otp_gen on
//  a free bank, advertises full banks to sd, recycles banks as sd releases
//  them, counts blocks over a session and flags protocol errors.
//  Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    otp_bank_sched_if.slave, see the interface for signal meanings
//  All outputs are registered.
module otp_bank_sched #(
    parameter int BLK_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    otp_bank_sched_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_t;

    localparam logic [BLK_W-1:0] ONE = {{(BLK_W-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    bank_t            bank_reg  [2];
    bank_t            bank_next [2];
    logic             wptr_reg, wptr_next;
    logic             rptr_reg, rptr_next;
    logic [BLK_W-1:0] gen_left_reg, gen_left_next;
    logic [BLK_W-1:0] rel_left_reg, rel_left_next;
    logic             gen_otp_reg, gen_otp_next;
    logic             new_otp_reg, new_otp_next;
    logic             wbank_reg, wbank_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;

    logic [1:0]       is_filling;
    logic             any_filling;
    logic             rd_full;
    logic             fire;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank_flag
            assign is_filling[gi] = (bank_reg[gi] == FILLING);
        end
    endgenerate

    // Only one bank can ever be FILLING, and it is always bank[wptr].
    assign any_filling = |is_filling;
    assign rd_full     = (bank_reg[rptr_reg] == FULL);
    assign fire        = (gen_left_reg != '0) && (bank_reg[wptr_reg] == EMPTY) && !any_filling;

    always_comb begin
        state_next    = state_reg;
        bank_next[0]  = bank_reg[0];
        bank_next[1]  = bank_reg[1];
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        gen_left_next = gen_left_reg;
        rel_left_next = rel_left_reg;
        gen_otp_next  = 1'b0;
        new_otp_next  = 1'b0;
        wbank_next    = wbank_reg;
        done_next     = 1'b0;
        err_next      = err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    err_next = 1'b0;
                    if (bus.blocks != '0) begin
                        // The first block is launched straight from the start
                        // pulse so that gen_otp lands one cycle later; it is
                        // the only block issued with new_otp=0. Pointers are
                        // re-aligned to bank 0 for every session.
                        state_next    = RUN;
                        gen_left_next = bus.blocks;
                        rel_left_next = bus.blocks;
                        wptr_next     = 1'b0;
                        rptr_next     = 1'b0;
                        bank_next[0]  = FILLING;
                        bank_next[1]  = EMPTY;
                        gen_otp_next  = 1'b1;
                        new_otp_next  = 1'b0;
                        wbank_next    = 1'b0;
                    end else begin
                        done_next = 1'b1;
                    end
                end
                if (bus.otp_done || bus.rel) begin
                    err_next = 1'b1;
                end
            end

            RUN: begin
                // Producer launch; cannot coincide with a valid otp_done
                // because launch needs no bank FILLING and otp_done needs one.
                if (fire) begin
                    bank_next[wptr_reg] = FILLING;
                    gen_otp_next        = 1'b1;
                    new_otp_next        = 1'b1;
                    wbank_next          = wptr_reg;
                end

                if (bus.otp_done) begin
                    if (any_filling) begin
                        bank_next[wptr_reg] = FULL;
                        wptr_next           = ~wptr_reg;
                        gen_left_next       = gen_left_reg - ONE;
                    end else begin
                        err_next = 1'b1;
                    end
                end

                // A valid release always targets the FULL bank at rptr, which
                // can never be the FILLING bank, so both updates coexist.
                if (bus.rel) begin
                    if (rd_full) begin
                        bank_next[rptr_reg] = EMPTY;
                        rptr_next           = ~rptr_reg;
                        rel_left_next       = rel_left_reg - ONE;
                        if (rel_left_reg == ONE) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase

        // Level outputs are computed from next state so they are registered
        // yet track the bank state without an extra cycle of lag.
        ready_next = (bank_next[rptr_next] == FULL);
        busy_next  = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bank_reg[0]  <= EMPTY;
            bank_reg[1]  <= EMPTY;
            wptr_reg     <= 1'b0;
            rptr_reg     <= 1'b0;
            gen_left_reg <= '0;
            rel_left_reg <= '0;
            gen_otp_reg  <= 1'b0;
            new_otp_reg  <= 1'b0;
            wbank_reg    <= 1'b0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            bank_reg[0]  <= bank_next[0];
            bank_reg[1]  <= bank_next[1];
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            gen_left_reg <= gen_left_next;
            rel_left_reg <= rel_left_next;
            gen_otp_reg  <= gen_otp_next;
            new_otp_reg  <= new_otp_next;
            wbank_reg    <= wbank_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    assign bus.gen_otp   = gen_otp_reg;
    assign bus.new_otp   = new_otp_reg;
    assign bus.wbank     = wbank_reg;
    assign bus.otp_ready = ready_reg;
    assign bus.rbank     = rptr_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
endmodule
